// File: rtl/data_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_deserializer: SSP serial-to-parallel receiver with FWFT RX FIFO,    |
// | fully oversampled on i_PCLK.                                              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_deserializer #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_PCLK,
  input  logic                  i_CLEAR_B,
  input  logic                  i_SSPCLKIN,
  input  logic                  i_SSPFSSIN,
  input  logic                  i_SSPRXD,
  input  logic                  i_RX_READ,
  input  logic                  i_CLR_ERR,
  output logic [DATA_WIDTH-1:0] o_RXDATA,
  output logic                  o_RX_VALID,
  output logic                  o_RX_FULL,
  output logic                  o_RX_OVERRUN,
  output logic                  o_FRAME_ERR
);

  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync, r_fss_sync, r_rxd_sync;
  logic                   r_clk_prev;
  state_t                 r_state;
  logic [c_CW-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]  r_shreg;
  logic [DATA_WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [c_PW-1:0]        r_wptr, r_rptr;
  logic [c_PW:0]          r_count;
  logic                   r_ovr, r_ferr;

  logic                  w_sample, w_fss, w_rxd, w_last, w_push;
  logic                  w_ferr_evt, w_full, w_empty, w_pop, w_wr, w_ovr_evt;
  logic [DATA_WIDTH-1:0] w_word;

  // Falling edge of the synchronized serial clock is the sample point
  assign w_sample   = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_fss      = r_fss_sync[SYNC_STAGES-1];
  assign w_rxd      = r_rxd_sync[SYNC_STAGES-1];
  assign w_word     = {r_shreg[DATA_WIDTH-2:0], w_rxd};
  assign w_last     = (r_cnt == c_CW'(DATA_WIDTH - 1));
  assign w_push     = (r_state == ST_SHIFT) & w_sample & w_last;
  assign w_ferr_evt = (r_state == ST_SHIFT) & w_sample & w_fss & ~w_last &
                      (r_cnt != '0);

  assign w_full    = (r_count == (c_PW+1)'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = i_RX_READ & ~w_empty;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovr_evt = w_push & w_full & ~w_pop;

  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      r_clk_sync <= '0;
      r_fss_sync <= '0;
      r_rxd_sync <= '0;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_SSPCLKIN};
      r_fss_sync <= {r_fss_sync[SYNC_STAGES-2:0], i_SSPFSSIN};
      r_rxd_sync <= {r_rxd_sync[SYNC_STAGES-2:0], i_SSPRXD};
      r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (w_sample) begin
      case (r_state)
        ST_IDLE: begin
          if (w_fss) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
          end
        end
        default: begin
          if (w_last) begin
            // FSS on the final bit chains straight into the next frame
            r_shreg <= w_word;
            r_cnt   <= '0;
            r_state <= w_fss ? ST_SHIFT : ST_IDLE;
          end else if (w_fss) begin
            r_cnt   <= '0;
          end else begin
            r_shreg <= w_word;
            r_cnt   <= r_cnt + c_CW'(1);
          end
        end
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero while empty
  always_ff @(posedge i_PCLK) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge i_PCLK or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovr   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + c_PW'(1);
      if (w_pop) r_rptr <= r_rptr + c_PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (c_PW+1)'(1);
        2'b01:   r_count <= r_count - (c_PW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_ovr  <= w_ovr_evt  | (r_ovr  & ~i_CLR_ERR);
      r_ferr <= w_ferr_evt | (r_ferr & ~i_CLR_ERR);
    end
  end

  assign o_RXDATA     = w_empty ? '0 : r_mem[r_rptr];
  assign o_RX_VALID   = ~w_empty;
  assign o_RX_FULL    = w_full;
  assign o_RX_OVERRUN = r_ovr;
  assign o_FRAME_ERR  = r_ferr;

endmodule
`default_nettype wire

// File: tb/tb_data_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_deserializer: directed scoreboard bench for data_deserializer.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_deserializer;

  logic       clk = 1'b0;
  logic       clear_b, sspclk, fss, rxd, rx_read, clr_err;
  logic [7:0] rxdata;
  logic       rx_valid, rx_full, rx_ovr, frame_err;

  int         n_cmp  = 0;
  int         n_fail = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  data_deserializer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .i_PCLK      (clk),
    .i_CLEAR_B   (clear_b),
    .i_SSPCLKIN  (sspclk),
    .i_SSPFSSIN  (fss),
    .i_SSPRXD    (rxd),
    .i_RX_READ   (rx_read),
    .i_CLR_ERR   (clr_err),
    .o_RXDATA    (rxdata),
    .o_RX_VALID  (rx_valid),
    .o_RX_FULL   (rx_full),
    .o_RX_OVERRUN(rx_ovr),
    .o_FRAME_ERR (frame_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One SSPCLK period (PCLK/4): data and FSS change with the rising edge
  task automatic send_bit(input logic f, input logic d);
    @(negedge clk);
    sspclk = 1'b1; fss = f; rxd = d;
    repeat (2) @(negedge clk);
    sspclk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_word(input logic [7:0] w, input logic fss_last);
    for (int i = 7; i >= 0; i--) send_bit((i == 0) && fss_last, w[i]);
  endtask

  task automatic read_word(input string tag);
    logic [7:0] e;
    check({tag, "_valid"}, rx_valid, 1);
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $error("FAIL %s_sb observed=read expected=empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rxdata, e);
    end
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_b = 1'b0; sspclk = 1'b0; fss = 1'b0; rxd = 1'b0;
    rx_read = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rxdata, 0);
    check("rst_full", rx_full, 0);
    check("rst_ovr", rx_ovr, 0);
    check("rst_ferr", frame_err, 0);
    clear_b = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single word, latency E -> E+1
    send_bit(1, 0);
    send_word(8'hA5, 0);
    check("t1_valid_at_E", rx_valid, 0);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    check("t1_valid_at_E1", rx_valid, 1);
    read_word("t1_rd");
    check("t1_empty", rx_valid, 0);
    check("t1_data0", rxdata, 0);

    // 2: back-to-back frames, FSS on last bit of the first
    send_bit(1, 0);
    exp_q.push_back(8'h3C); send_word(8'h3C, 1);
    exp_q.push_back(8'hC3); send_word(8'hC3, 0);
    @(negedge clk);
    check("t2_ferr", frame_err, 0);
    read_word("t2_rd0");
    read_word("t2_rd1");
    check("t2_empty", rx_valid, 0);

    // 3: overrun, fifth word lost
    for (int k = 0; k < 5; k++) begin
      send_bit(1, 0);
      if (k < 4) exp_q.push_back(8'h10 + 8'(k));
      send_word(8'h10 + 8'(k), 0);
    end
    @(negedge clk);
    check("t3_full", rx_full, 1);
    check("t3_ovr", rx_ovr, 1);
    for (int k = 0; k < 4; k++) read_word("t3_rd");
    check("t3_empty", rx_valid, 0);
    check("t3_notfull", rx_full, 0);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("t3_ovr_clr", rx_ovr, 0);

    // 4: frame error after 3 bits, then clean frame
    send_bit(1, 0);
    send_bit(0, 1); send_bit(0, 0); send_bit(0, 1);
    send_bit(1, 0);
    exp_q.push_back(8'h81);
    send_word(8'h81, 0);
    @(negedge clk);
    check("t4_ferr", frame_err, 1);
    read_word("t4_rd");
    check("t4_empty", rx_valid, 0);
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    check("t4_ferr_clr", frame_err, 0);

    // 5: push into a full FIFO coinciding with a read
    for (int k = 0; k < 4; k++) begin
      send_bit(1, 0);
      exp_q.push_back(8'h21 + 8'(k));
      send_word(8'h21 + 8'(k), 0);
    end
    send_bit(1, 0);
    for (int i = 7; i >= 1; i--) send_bit(0, 1'(8'h25 >> i));
    send_bit(0, 1'b1);
    check("t5_full_at_E", rx_full, 1);
    check("t5_head", rxdata, exp_q.pop_front());
    exp_q.push_back(8'h25);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    check("t5_full_after", rx_full, 1);
    check("t5_no_ovr", rx_ovr, 0);
    for (int k = 0; k < 4; k++) read_word("t5_rd");
    check("t5_empty", rx_valid, 0);

    // 6: async reset mid-frame discards everything
    send_bit(1, 0);
    send_word(8'h77, 0);
    send_bit(1, 0);
    send_bit(0, 1); send_bit(0, 1); send_bit(0, 0); send_bit(0, 1);
    check("t6_pre_valid", rx_valid, 1);
    #3 clear_b = 1'b0;
    #1;
    check("t6_rst_valid", rx_valid, 0);
    check("t6_rst_data", rxdata, 0);
    check("t6_rst_full", rx_full, 0);
    check("t6_rst_ferr", frame_err, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    clear_b = 1'b1;
    send_bit(1, 0);
    exp_q.push_back(8'h5A);
    send_word(8'h5A, 0);
    @(negedge clk);
    read_word("t6_rd");
    check("t6_empty", rx_valid, 0);
    check("t6_ferr", frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
